ex_muldiv: RTL

//  Multi-cycle RV32M multiply/divide unit beside the single-cycle execute stage.
//  The execute stage issues one M-extension op with a start pulse.

---
 rtl/ex_muldiv_if.sv | 28 ++
 rtl/ex_muldiv.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: issue and write-back bundle between execute stage and muldiv.
// master = execute stage (issue, flush), slave = ex_muldiv (hold, write-back).
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_rdata;
  logic [XLEN-1:0] rs2_rdata;
  logic [4:0]      rd_waddr;
  logic            flush;
  logic            hold_o;
  logic            done_o;
  logic [4:0]      rd_waddr_o;
  logic [XLEN-1:0] rd_wdata_o;

  modport master (
    output start, op, rs1_rdata, rs2_rdata,
    output rd_waddr, flush,
    input  hold_o, done_o, rd_waddr_o, rd_wdata_o
  );

  modport slave (
    input  start, op, rs1_rdata, rs2_rdata,
    input  rd_waddr, flush,
    output hold_o, done_o, rd_waddr_o, rd_wdata_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative radix-2 RV32M multiply/divide unit.
// Ports: clk, rst (sync, active-high), io (ex_muldiv_if.slave).
// MULDIV_FAST_MUL_EN: single-cycle '*' multiplies; divide stays iterative.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave io
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic            is_div, a_sgn, b_sgn;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  // Only signed operands contribute a sign bit.
  always_comb begin
    is_div = io.op[2];
    a_sgn  = io.rs1_rdata[XLEN-1] &
             ~(io.op[0] & (io.op[1] | io.op[2]));
    b_sgn  = io.rs2_rdata[XLEN-1] &
             ((io.op[2] & ~io.op[0]) |
              (io.op[2:1] == 2'b00));
    abs_a  = a_sgn ? -io.rs1_rdata : io.rs1_rdata;
    abs_b  = b_sgn ? -io.rs2_rdata : io.rs2_rdata;
    div_zero = is_div & (io.rs2_rdata == '0);
    div_ovf  = is_div & ~io.op[0] &
               (io.rs1_rdata == MIN_NEG) &
               (io.rs2_rdata == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN+1:0] fp;
  logic [XLEN-1:0]          fast_res;

  always_comb begin
    fa = {a_sgn, io.rs1_rdata};
    fb = {b_sgn, io.rs2_rdata};
    fp = fa * fb;
    fast_res = (io.op[1:0] == 2'd0) ?
               XLEN'(fp) : XLEN'(fp >>> XLEN);
  end
`endif

  // Datapath steps. Multiply: acc = {hi, multiplier},
  // b_q = multiplicand. Divide: acc = {rem, dividend/quo}.
  logic [XLEN:0]     mul_sum, rem_sh;
  logic              rem_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
              {1'b0, b_q & {XLEN{acc_q[0]}}};
    rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_ge  = rem_sh >= {1'b0, b_q};
    prod    = neg_q ? -acc_q : acc_q;
    quo     = neg_q ? -acc_q[XLEN-1:0] :
                       acc_q[XLEN-1:0];
    rem     = neg_q ? -acc_q[2*XLEN-1:XLEN] :
                       acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    acc_d   = acc_q;
    b_d     = b_q;
    neg_d   = neg_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (io.start & ~io.flush) begin
          op_d  = io.op;
          rd_d  = io.rd_waddr;
          cnt_d = CNT_W'(XLEN);
          // Remainder takes the dividend's sign.
          neg_d = (io.op[2] & io.op[1]) ?
                  a_sgn : (a_sgn ^ b_sgn);
          if (div_zero) begin
            res_d   = io.op[1] ? io.rs1_rdata : '1;
            state_d = DONE;
          end else if (div_ovf) begin
            res_d   = io.op[1] ? '0 : io.rs1_rdata;
            state_d = DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (~is_div) begin
            res_d   = fast_res;
            state_d = DONE;
          end
`endif
          else begin
            acc_d = {{XLEN{1'b0}},
                     is_div ? abs_a : abs_b};
            b_d   = is_div ? abs_b : abs_a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q[2]) begin
          acc_d = {rem_ge ?
                   XLEN'(rem_sh - {1'b0, b_q}) :
                   rem_sh[XLEN-1:0],
                   acc_q[XLEN-2:0], rem_ge};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[2]) begin
          res_d = op_q[1] ? rem : quo;
        end else begin
          res_d = (op_q[1:0] == 2'd0) ?
                  prod[XLEN-1:0] :
                  prod[2*XLEN-1:XLEN];
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (io.flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  // Flush in the DONE cycle kills the write-back.
  assign io.done_o     = (state_q == DONE) & ~io.flush;
  assign io.rd_waddr_o = io.done_o ? rd_q : 5'd0;
  assign io.rd_wdata_o = io.done_o ? res_q : '0;
  // Low in DONE so the pc advances with write-back.
  assign io.hold_o = (io.start & (state_q == IDLE) &
                      ~io.flush) |
                     (state_q == CALC) |
                     (state_q == FIX);
endmodule
